// File: rtl/if_fetch_queue.sv
// if_fetch_queue: sequential instruction fetch with in-order tag FIFO, instruction queue and redirect flush
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          req_en;
  logic [31:0]   fetch_pc;
  logic [31:0]   last_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] t_head;
  logic [AW-1:0] t_tail;
  logic [31:0]   q_inst [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   t_pc   [QDEPTH];
  logic          credit;
  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;
  logic          has;

  // handshake decode and head-of-queue presentation
  always_comb begin
    credit    = ({1'b0, count} + {1'b0, outstanding}) < QD;
    im_req    = req_en & ~redirect_valid & credit;
    im_addr   = {fetch_pc[31:2], 2'b00};
    grant     = im_req & im_gnt;
    resp      = im_rvalid & (|outstanding);
    push      = resp & ~(|discard) & ~redirect_valid;
    has       = |count;
    id_valid  = has & ~redirect_valid;
    pop       = id_valid & id_ready;
    id_inst   = has ? q_inst[head] : NOP;
    id_pc     = has ? q_pc[head] : last_pc;
    id_opcode = id_inst[6:0];
    id_funct3 = id_inst[14:12];
  end

  // control state: fetch pointer, credits, discard count and queue pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_en      <= 1'b0;
      fetch_pc    <= RESET_PC;
      last_pc     <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      head        <= '0;
      tail        <= '0;
      t_head      <= '0;
      t_tail      <= '0;
    end else begin
      req_en      <= 1'b1;
      last_pc     <= id_pc;
      outstanding <= outstanding + CW'(grant) - CW'(resp);
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
        t_tail   <= t_tail + AW'(1);
      end
      if (resp) t_head <= t_head + AW'(1);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        discard  <= outstanding - CW'(resp);
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (resp && |discard) discard <= discard - CW'(1);
        if (push) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // storage for granted address tags and returned instructions
  always_ff @(posedge clk) begin
    if (grant) t_pc[t_tail] <= im_addr;
    if (push) begin
      q_inst[tail] <= im_rdata;
      q_pc[tail]   <= t_pc[t_head];
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized and directed checks of if_fetch_queue against a queue-based reference model
module tb_if_fetch_queue;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int QD = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;

  if_fetch_queue #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .rstn(rstn),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_funct3(id_funct3)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] m_fetch;
  logic        m_started;
  logic [31:0] iq_inst[$];
  logic [31:0] iq_pc[$];
  logic [31:0] inf_pc[$];
  bit          inf_dead[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    iq_inst.delete();
    iq_pc.delete();
    inf_pc.delete();
    inf_dead.delete();
    m_fetch = RPC;
    m_started = 1'b0;
  endtask

  // one clock cycle: drive inputs, check outputs against the model, advance the model at the edge
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdr, input logic [31:0] rp, input logic rdy);
    logic er;
    logic ev;
    logic [31:0] h;
    logic [31:0] p;
    bit d;
    @(negedge clk);
    im_gnt = g;
    im_rvalid = rv;
    im_rdata = rd;
    redirect_valid = rdr;
    redirect_pc = rp;
    id_ready = rdy;
    #1;
    er = rstn && m_started && !rdr && (iq_pc.size() + inf_pc.size() < QD);
    ev = rstn && iq_pc.size() > 0 && !rdr;
    check("im_req", im_req, er);
    if (er) check("im_addr", im_addr, {m_fetch[31:2], 2'b00});
    check("id_valid", id_valid, ev);
    if (ev) begin
      h = iq_inst[0];
      check("id_pc", id_pc, iq_pc[0]);
      check("id_inst", id_inst, h);
      check("id_opcode", id_opcode, h[6:0]);
      check("id_funct3", id_funct3, h[14:12]);
    end else if (iq_pc.size() == 0) begin
      check("nop_inst", id_inst, NOP);
      check("nop_opcode", id_opcode, 32'h13);
      check("nop_funct3", id_funct3, 32'h0);
    end
    @(posedge clk);
    if (rstn) begin
      if (ev && rdy) begin
        void'(iq_inst.pop_front());
        void'(iq_pc.pop_front());
      end
      if (rv && inf_pc.size() > 0) begin
        p = inf_pc.pop_front();
        d = inf_dead.pop_front();
        if (!d && !rdr) begin
          iq_inst.push_back(rd);
          iq_pc.push_back(p);
        end
      end
      if (er && g) begin
        inf_pc.push_back({m_fetch[31:2], 2'b00});
        inf_dead.push_back(1'b0);
        m_fetch = m_fetch + 32'd4;
      end
      if (rdr) begin
        iq_inst.delete();
        iq_pc.delete();
        foreach (inf_dead[i]) inf_dead[i] = 1'b1;
        m_fetch = {rp[31:2], 2'b00};
      end
      m_started = 1'b1;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_im_req", im_req, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_inst", id_inst, NOP);
    check("rst_id_pc", id_pc, 0);
    cyc(0, 1, $urandom, 0, 0, 1);
    cyc(1, 1, $urandom, 0, 0, 1);
    #1 rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check("init_im_req", im_req, 0);
    check("init_id_valid", id_valid, 0);
    check("init_id_inst", id_inst, NOP);
    check("init_id_pc", id_pc, 0);
    cyc(1, 0, 0, 0, 0, 1);
    #1 rstn = 1'b1;
    // streaming with a one-cycle memory and an always-ready decoder
    for (int i = 0; i < 10; i++) cyc(1, 1, $urandom, 0, 0, 1);
    // decoder stalls: queue fills to capacity, requests stop
    for (int i = 0; i < 8; i++) cyc(1, 1, $urandom, 0, 0, 0);
    check("full_count", iq_pc.size(), QD);
    for (int i = 0; i < 8; i++) cyc(1, 1, $urandom, 0, 0, 1);
    // grant withheld: address must stay put
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    // drain everything, then two outstanding fetches and a redirect
    for (int i = 0; i < 6; i++) cyc(0, 1, $urandom, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    check("two_outstanding", inf_pc.size(), 2);
    cyc(1, 0, 0, 1, 32'h0000_2002, 1);
    for (int i = 0; i < 10; i++) cyc(1, 1, $urandom, 0, 0, 1);
    // reset pulse with fetches in flight, then redirect racing a response
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    reset_pulse();
    cyc(0, 1, $urandom, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, $urandom, 1, 32'h0000_3000, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, $urandom, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) reset_pulse();
      else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
               $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
